// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic stream source: NLFSR tap masks,
// FSM state encoding and the period-length helper.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sc_state_e;

    // Maximal-length Fibonacci masks for a left-shifting register, indexed by WIDTH.
    // Bit WIDTH-1 is always set so the zero-state insertion closes the de Bruijn cycle.
    localparam logic [7:0] TAPS [0:8] = '{
        8'b0000_0000,
        8'b0000_0000,
        8'b0000_0000,
        8'b0000_0110,  // x^3 + x + 1
        8'b0000_1100,  // x^4 + x + 1
        8'b0001_0100,  // x^5 + x^2 + 1
        8'b0011_0000,  // x^6 + x + 1
        8'b0110_0000,  // x^7 + x + 1
        8'b1000_1110   // x^8 + x^6 + x^5 + x^4 + 1
    };

    function automatic int unsigned period_len(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/sc_debruijn_gen.sv
// De Bruijn NLFSR: an LFSR with the all-zero state spliced in, so it walks every
// WIDTH-bit value exactly once per 2^WIDTH steps.
module sc_debruijn_gen
    import sc_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] rnd
);

    localparam logic [7:0]       TAP_ROW = TAPS[WIDTH];
    localparam logic [WIDTH-1:0] MASK    = TAP_ROW[WIDTH-1:0];

    logic [WIDTH-1:0] rnd_q;
    logic [WIDTH-1:0] rnd_d;
    logic             fb;

    // Flipping feedback when the surviving bits are all zero inserts/leaves state 0.
    assign fb = (^(rnd_q & MASK)) ^ (rnd_q[WIDTH-2:0] == '0);

    always_comb begin
        rnd_d = rnd_q;
        if (load) begin
            rnd_d = SEED;
        end else if (step) begin
            rnd_d = {rnd_q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q <= SEED;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign rnd = rnd_q;

endmodule

// File: rtl/sc_stream_source.sv
// Stochastic number generator: buffers operands over valid/ready and emits one
// unipolar bitstream period per operand, plus the correlator's sequence/enable.
module sc_stream_source
    import sc_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] in_value,
    input  logic           stop,
    output logic           bit_out,
    output logic [WIDTH:0] counter_sob,
    output logic           corr_enable,
    output logic           period_done,
    output logic           busy
);

    localparam int unsigned    PLEN   = period_len(WIDTH);
    localparam logic [WIDTH:0] PERIOD = PLEN[WIDTH:0];
    localparam logic [WIDTH:0] LAST   = PERIOD - 1'b1;
    localparam logic [WIDTH:0] ONE    = {{WIDTH{1'b0}}, 1'b1};

    sc_state_e      state_q, state_d;
    logic [WIDTH:0] cnt_q, cnt_d;
    logic [WIDTH:0] active_q, active_d;
    logic [WIDTH:0] pend_q, pend_d;
    logic           pend_v_q, pend_v_d;
    logic           stop_f_q, stop_f_d;
    logic           first_q, first_d;
    logic           en_q, en_d;

    logic             accept;
    logic [WIDTH:0]   in_sat;
    logic             rnd_load;
    logic             rnd_step;
    logic [WIDTH-1:0] rnd;

    sc_debruijn_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (rnd_load),
        .step (rnd_step),
        .rnd  (rnd)
    );

    assign accept = in_valid & ~pend_v_q;
    assign in_sat = (in_value > PERIOD) ? PERIOD : in_value;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        stop_f_d = stop_f_q;
        first_d  = first_q;
        en_d     = en_q;
        rnd_load = 1'b0;
        rnd_step = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    active_d = pend_q;
                    pend_v_d = 1'b0;
                    cnt_d    = PERIOD;
                    first_d  = 1'b1;
                    rnd_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                rnd_step = 1'b1;
                if (stop) begin
                    stop_f_d = 1'b1;
                end
                if (cnt_q == PERIOD) begin
                    first_d = 1'b0;
                end
                if (cnt_q == LAST) begin
                    // Every boundary hands a finished period to the correlator.
                    cnt_d = PERIOD;
                    en_d  = 1'b1;
                    if (pend_v_q) begin
                        active_d = pend_q;
                        pend_v_d = 1'b0;
                    end else if (stop_f_q) begin
                        state_d = FLUSH;
                    end
                end else if (cnt_q == PERIOD) begin
                    cnt_d = ONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                cnt_d    = '0;
                stop_f_d = 1'b0;
                en_d     = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            pend_d   = in_sat;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            stop_f_q <= 1'b0;
            first_q  <= 1'b1;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            stop_f_q <= stop_f_d;
            first_q  <= first_d;
            en_q     <= en_d;
        end
    end

    assign in_ready    = ~pend_v_q;
    assign bit_out     = (state_q == RUN) & ({1'b0, rnd} < active_q);
    assign counter_sob = cnt_q;
    assign corr_enable = en_q;
    assign period_done = (cnt_q == PERIOD) & ~first_q;
    assign busy        = (state_q != IDLE);

endmodule
